// File: rtl/bayer_pkg.sv
// Shared types and helpers for the Bayer demosaic pipeline: CFA phase decode,
// RGB565 packing and the fixed input-to-output latency.
package bayer_pkg;

  localparam int DEMOSAIC_LAT = 3;

  typedef enum logic [1:0] {
    PH_B  = 2'd0,
    PH_GB = 2'd1,
    PH_GR = 2'd2,
    PH_R  = 2'd3
  } phase_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Index {row parity, column parity} relative to the BGGR origin.
  function automatic phase_t phase_of(input logic x0, input logic y0, input logic [1:0] pattern);
    return phase_t'({y0 ^ pattern[1], x0 ^ pattern[0]});
  endfunction

  function automatic logic [15:0] pack_rgb565(input rgb888_t px);
    return {px.r[7:3], px.g[7:2], px.b[7:3]};
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One raw image line of storage: simple dual-port RAM with a registered read
// port; a read and a write to the same address in one cycle returns old data.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/bayer_demosaic.sv
// Bilinear 3x3 demosaic of a raw Bayer stream into RGB565 with frame-buffer
// addresses; fixed-latency pipeline with no backpressure.
module bayer_demosaic
  import bayer_pkg::*;
#(
  parameter  int WIDTH   = 640,
  parameter  int HEIGHT  = 480,
  parameter  int PATTERN = 0,
  localparam int XW      = $clog2(WIDTH),
  localparam int YW      = $clog2(HEIGHT),
  localparam int AW      = $clog2(WIDTH * HEIGHT)
) (
  input  logic          PCLK,
  input  logic          RST_N,
  input  logic [7:0]    i_pixel,
  input  logic          i_DV,
  input  logic [XW-1:0] i_pixel_x,
  input  logic [YW-1:0] i_pixel_y,
  output logic [15:0]   o_RGB,
  output logic          o_DV,
  output logic [XW-1:0] o_pixel_x,
  output logic [YW-1:0] o_pixel_y,
  output logic [AW-1:0] o_addr
);

  localparam logic [XW:0] X_LIM = (XW + 1)'(WIDTH);
  localparam logic [YW:0] Y_LIM = (YW + 1)'(HEIGHT);
  localparam logic [1:0]  PAT   = 2'(PATTERN);

  // ---------------- input capture ----------------
  logic          accept;
  logic          origin;
  logic          frame_ok_reg;
  logic          frame_ok_next;
  logic          in_vld_reg;
  logic          in_qual_reg;
  logic [7:0]    in_pix_reg;
  logic [XW-1:0] in_x_reg;
  logic [YW-1:0] in_y_reg;

  assign accept        = i_DV && ({1'b0, i_pixel_x} < X_LIM) && ({1'b0, i_pixel_y} < Y_LIM);
  assign origin        = (i_pixel_x == '0) && (i_pixel_y == '0);
  assign frame_ok_next = frame_ok_reg | (accept & origin);

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_ok_reg <= 1'b0;
      in_vld_reg   <= 1'b0;
      in_qual_reg  <= 1'b0;
      in_pix_reg   <= '0;
      in_x_reg     <= '0;
      in_y_reg     <= '0;
    end else begin
      frame_ok_reg <= frame_ok_next;
      in_vld_reg   <= accept;
      // Rows 0/1 and columns 0/1 only prime the line buffers and window.
      in_qual_reg  <= accept && frame_ok_next &&
                      (i_pixel_x >= XW'(2)) && (i_pixel_y >= YW'(2));
      if (accept) begin
        in_pix_reg <= i_pixel;
        in_x_reg   <= i_pixel_x;
        in_y_reg   <= i_pixel_y;
      end
    end
  end

  // ---------------- S1: line-buffer read ----------------
  logic [7:0]    lb0_q;
  logic [7:0]    lb1_q;
  logic          s1_vld_reg;
  logic          s1_qual_reg;
  logic [7:0]    s1_pix_reg;
  logic [XW-1:0] s1_x_reg;
  logic [YW-1:0] s1_y_reg;

  line_buffer #(.DEPTH(WIDTH), .AW(XW)) u_lb0 (
    .clk     (PCLK),
    .wr_en   (in_vld_reg),
    .wr_addr (in_x_reg),
    .wr_data (in_pix_reg),
    .rd_en   (in_vld_reg),
    .rd_addr (in_x_reg),
    .rd_data (lb0_q)
  );

  // LB1 takes the row LB0 just displaced, so its write trails by one cycle.
  line_buffer #(.DEPTH(WIDTH), .AW(XW)) u_lb1 (
    .clk     (PCLK),
    .wr_en   (s1_vld_reg),
    .wr_addr (s1_x_reg),
    .wr_data (lb0_q),
    .rd_en   (in_vld_reg),
    .rd_addr (in_x_reg),
    .rd_data (lb1_q)
  );

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_vld_reg  <= 1'b0;
      s1_qual_reg <= 1'b0;
      s1_pix_reg  <= '0;
      s1_x_reg    <= '0;
      s1_y_reg    <= '0;
    end else begin
      s1_vld_reg  <= in_vld_reg;
      s1_qual_reg <= in_qual_reg;
      if (in_vld_reg) begin
        s1_pix_reg <= in_pix_reg;
        s1_x_reg   <= in_x_reg;
        s1_y_reg   <= in_y_reg;
      end
    end
  end

  // ---------------- S2: window shift + centre coordinates ----------------
  logic [7:0]    win_reg [3][3];
  logic [7:0]    new_col [3];
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          s2_vld_reg;
  phase_t        s2_phase_reg;
  logic [XW-1:0] s2_x_reg;
  logic [YW-1:0] s2_y_reg;
  logic [AW-1:0] s2_addr_reg;

  assign new_col[0] = lb1_q;
  assign new_col[1] = lb0_q;
  assign new_col[2] = s1_pix_reg;
  assign cx         = s1_x_reg - XW'(1);
  assign cy         = s1_y_reg - YW'(1);

  // Row 0 is y-2, row 2 is y; column 2 is the newest pixel.
  always_ff @(posedge PCLK) begin
    if (s1_vld_reg) begin
      for (int r = 0; r < 3; r++) begin
        win_reg[r][0] <= win_reg[r][1];
        win_reg[r][1] <= win_reg[r][2];
        win_reg[r][2] <= new_col[r];
      end
    end
  end

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      s2_vld_reg   <= 1'b0;
      s2_phase_reg <= PH_B;
      s2_x_reg     <= '0;
      s2_y_reg     <= '0;
      s2_addr_reg  <= '0;
    end else begin
      s2_vld_reg <= s1_vld_reg & s1_qual_reg;
      if (s1_vld_reg && s1_qual_reg) begin
        s2_phase_reg <= phase_of(cx[0], cy[0], PAT);
        s2_x_reg     <= cx;
        s2_y_reg     <= cy;
        s2_addr_reg  <= AW'(cy) * AW'(WIDTH) + AW'(cx);
      end
    end
  end

  // ---------------- S3: interpolate + output register ----------------
  logic [7:0] c_pix, n_pix, s_pix, e_pix, w_pix;
  logic [9:0] orth_sum;
  logic [9:0] diag_sum;
  logic [8:0] ew_sum;
  logic [8:0] ns_sum;
  logic [7:0] orth_avg, diag_avg, ew_avg, ns_avg;
  rgb888_t    px;

  assign c_pix    = win_reg[1][1];
  assign n_pix    = win_reg[0][1];
  assign s_pix    = win_reg[2][1];
  assign w_pix    = win_reg[1][0];
  assign e_pix    = win_reg[1][2];
  assign orth_sum = 10'(n_pix) + 10'(s_pix) + 10'(e_pix) + 10'(w_pix);
  assign diag_sum = 10'(win_reg[0][0]) + 10'(win_reg[0][2]) +
                    10'(win_reg[2][0]) + 10'(win_reg[2][2]);
  assign ew_sum   = 9'(e_pix) + 9'(w_pix);
  assign ns_sum   = 9'(n_pix) + 9'(s_pix);
  assign orth_avg = orth_sum[9:2];
  assign diag_avg = diag_sum[9:2];
  assign ew_avg   = ew_sum[8:1];
  assign ns_avg   = ns_sum[8:1];

  always_comb begin
    px = '0;
    case (s2_phase_reg)
      PH_B: begin
        px.b = c_pix;
        px.g = orth_avg;
        px.r = diag_avg;
      end
      PH_R: begin
        px.r = c_pix;
        px.g = orth_avg;
        px.b = diag_avg;
      end
      PH_GB: begin
        px.g = c_pix;
        px.b = ew_avg;
        px.r = ns_avg;
      end
      PH_GR: begin
        px.g = c_pix;
        px.r = ew_avg;
        px.b = ns_avg;
      end
      default: px = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      o_DV      <= 1'b0;
      o_RGB     <= '0;
      o_pixel_x <= '0;
      o_pixel_y <= '0;
      o_addr    <= '0;
    end else begin
      o_DV <= s2_vld_reg;
      if (s2_vld_reg) begin
        o_RGB     <= pack_rgb565(px);
        o_pixel_x <= s2_x_reg;
        o_pixel_y <= s2_y_reg;
        o_addr    <= s2_addr_reg;
      end
    end
  end

endmodule

// File: tb/tb_bayer_demosaic.sv
// Self-checking bench for bayer_demosaic on an 8x6 frame: scoreboard fed by a
// neighbour-averaging reference model, latency, counts and reset behaviour.
module tb_bayer_demosaic;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int PAT = 0;

  logic        PCLK = 1'b0;
  logic        RST_N;
  logic [7:0]  i_pixel;
  logic        i_DV;
  logic [2:0]  i_pixel_x;
  logic [2:0]  i_pixel_y;
  logic [15:0] o_RGB;
  logic        o_DV;
  logic [2:0]  o_pixel_x;
  logic [2:0]  o_pixel_y;
  logic [5:0]  o_addr;

  bayer_demosaic #(.WIDTH(W), .HEIGHT(H), .PATTERN(PAT)) dut (
    .PCLK      (PCLK),
    .RST_N     (RST_N),
    .i_pixel   (i_pixel),
    .i_DV      (i_DV),
    .i_pixel_x (i_pixel_x),
    .i_pixel_y (i_pixel_y),
    .o_RGB     (o_RGB),
    .o_DV      (o_DV),
    .o_pixel_x (o_pixel_x),
    .o_pixel_y (o_pixel_y),
    .o_addr    (o_addr)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] rgb;
    int          x;
    int          y;
    int          addr;
    int          scyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  img [H][W];
  string       pat_str [4] = '{"BGGR", "GBRG", "GRBG", "RGGB"};
  int          err_cnt  = 0;
  int          chk_cnt  = 0;
  int          dv_total = 0;
  int          first_addr = -1;
  logic        frame_ok_tb = 1'b0;
  logic        ramp_mode = 1'b0;
  logic [15:0] ramp_seen = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Colour letter of the CFA site at (x,y).
  function automatic byte site(input int x, input int y);
    return pat_str[PAT].getc((y % 2) * 2 + (x % 2));
  endfunction

  // Each missing channel is the truncated mean of same-colour 3x3 neighbours.
  function automatic logic [15:0] ref_rgb(input int cx, input int cy);
    string      chans = "RGB";
    int         sum [3];
    int         cnt [3];
    logic [7:0] v   [3];
    for (int k = 0; k < 3; k++) begin
      sum[k] = 0;
      cnt[k] = 0;
    end
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0)
          for (int k = 0; k < 3; k++)
            if (site(cx + dx, cy + dy) == chans.getc(k)) begin
              sum[k] += int'(img[cy + dy][cx + dx]);
              cnt[k]++;
            end
    for (int k = 0; k < 3; k++) begin
      if (site(cx, cy) == chans.getc(k)) v[k] = img[cy][cx];
      else if (cnt[k] > 0)               v[k] = 8'(sum[k] / cnt[k]);
      else                               v[k] = '0;
    end
    return {v[0][7:3], v[1][7:2], v[2][7:3]};
  endfunction

  task automatic fill(input int scene);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (scene)
          0:       img[y][x] = 8'h80;
          1:       img[y][x] = (site(x, y) == "R") ? 8'hFF : 8'h00;
          2:       img[y][x] = 8'($urandom_range(0, 255));
          default: img[y][x] = 8'(16 * x);
        endcase
  endtask

  task automatic drive(input int x, input int y, input logic [7:0] p);
    exp_t e;
    @(negedge PCLK);
    i_DV      = 1'b1;
    i_pixel_x = 3'(x);
    i_pixel_y = 3'(y);
    i_pixel   = p;
    if (x == 0 && y == 0) frame_ok_tb = 1'b1;
    if (frame_ok_tb && x >= 2 && y >= 2) begin
      e.rgb  = ref_rgb(x - 1, y - 1);
      e.x    = x - 1;
      e.y    = y - 1;
      e.addr = (y - 1) * W + (x - 1);
      e.scyc = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge PCLK);
      i_DV = 1'b0;
    end
  endtask

  // Valid strobe with an out-of-range row: must be ignored entirely.
  task automatic junk();
    @(negedge PCLK);
    i_DV      = 1'b1;
    i_pixel_x = 3'($urandom_range(0, 7));
    i_pixel_y = 3'($urandom_range(6, 7));
    i_pixel   = 8'($urandom_range(0, 255));
  endtask

  task automatic drive_span(input int y0, input int x0, input int y1, input int mode);
    for (int y = y0; y <= y1; y++)
      for (int x = (y == y0 ? x0 : 0); x < W; x++) begin
        drive(x, y, img[y][x]);
        if (mode == 1)      idle_cycles(1);
        else if (mode == 2) junk();
      end
  endtask

  task automatic run_frame(input string name, input int mode);
    int start;
    start = dv_total;
    drive_span(0, 0, H - 1, mode);
    idle_cycles(8);
    check_val({name, "_dv_count"}, 32'(dv_total - start), 32'((W - 2) * (H - 2)));
  endtask

  task automatic check_outputs_zero(input string name);
    check_val({name, "_rgb"},  32'(o_RGB),     32'h0);
    check_val({name, "_dv"},   32'(o_DV),      32'h0);
    check_val({name, "_x"},    32'(o_pixel_x), 32'h0);
    check_val({name, "_y"},    32'(o_pixel_y), 32'h0);
    check_val({name, "_addr"}, 32'(o_addr),    32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    RST_N     = 1'b0;
    i_DV      = 1'b0;
    i_pixel   = '0;
    i_pixel_x = '0;
    i_pixel_y = '0;

    fork
      forever begin
        exp_t e;
        @(negedge PCLK);
        if (o_DV) begin
          dv_total++;
          $display("out x=%0d y=%0d rgb=%04h addr=%0d cyc=%0d",
                   o_pixel_x, o_pixel_y, o_RGB, o_addr, cyc);
          if (first_addr < 0) first_addr = int'(o_addr);
          if (ramp_mode && o_pixel_x == 3'd3 && o_pixel_y == 3'd2) ramp_seen = o_RGB;
          if (exp_q.size() == 0) begin
            check_val("unexpected_dv", 32'(o_DV), 32'h0);
          end else begin
            e = exp_q.pop_front();
            check_val("rgb",     32'(o_RGB),     32'(e.rgb));
            check_val("x",       32'(o_pixel_x), 32'(e.x));
            check_val("y",       32'(o_pixel_y), 32'(e.y));
            check_val("addr",    32'(o_addr),    32'(e.addr));
            check_val("latency", 32'(cyc - e.scyc), 32'd3);
          end
        end
      end
    join_none

    repeat (3) @(negedge PCLK);
    check_outputs_zero("reset");
    RST_N = 1'b1;
    idle_cycles(2);

    fill(0);
    run_frame("flat", 0);
    check_val("first_addr", 32'(first_addr), 32'd9);

    fill(1);
    run_frame("red", 0);

    fill(2);
    run_frame("rand_b2b", 0);
    run_frame("rand_gap", 1);
    run_frame("rand_junk", 2);

    fill(3);
    ramp_mode = 1'b1;
    run_frame("ramp", 0);
    ramp_mode = 1'b0;
    check_val("ramp_gb_centre", 32'(ramp_seen), 32'h3186);

    // Reset asserted part-way through row 3.
    fill(2);
    drive_span(0, 0, 2, 0);
    for (int x = 0; x < 4; x++) drive(x, 3, img[3][x]);
    @(negedge PCLK);
    i_DV = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    frame_ok_tb = 1'b0;
    repeat (3) @(negedge PCLK);
    RST_N = 1'b1;
    start = dv_total;
    drive_span(3, 4, H - 1, 0);
    idle_cycles(8);
    check_val("post_reset_dv_count", 32'(dv_total - start), 32'd0);

    fill(2);
    run_frame("after_reset", 0);

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bayer_demosaic.md
# bayer_demosaic

Bilinear 3x3 Bayer demosaicing stage for the OV7670 raw pixel path. Consumes the 8-bit raw Bayer stream (pixel, DV, x/y coordinates) produced by the camera capture stage and emits RGB565 pixels with frame-buffer addresses. It sits directly downstream of capture and upstream of the frame-buffer write port. Uses two internal line buffers and runs entirely in the PCLK domain.

## Interface
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- PATTERN, 0, Bayer phase at (0,0): 0=BGGR (OV7670 raw), 1=GBRG, 2=GRBG, 3=RGGB
- PCLK  in  1  pixel clock; all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- i_pixel  in  8  raw Bayer sample
- i_DV  in  1  i_pixel/i_pixel_x/i_pixel_y valid this cycle
- i_pixel_x  in  $clog2(WIDTH)  column of i_pixel
- i_pixel_y  in  $clog2(HEIGHT)  row of i_pixel
- o_RGB  out  16  RGB565 {R[7:3],G[7:2],B[7:3]}
- o_DV  out  1  output valid, one-cycle pulse per pixel
- o_pixel_x  out  $clog2(WIDTH)  column of output pixel
- o_pixel_y  out  $clog2(HEIGHT)  row of output pixel
- o_addr  out  $clog2(WIDTH*HEIGHT)  o_pixel_y*WIDTH + o_pixel_x

## Operation
- Line buffers LB0 (row y-1) and LB1 (row y-2), depth WIDTH, addressed by i_pixel_x. On accepted input: read LB0[x], LB1[x]; write LB1[x]<=old LB0[x], LB0[x]<=i_pixel (read-before-write).
- 3x3 window: three rows x three columns of registers; shifts one column only on valid pipeline data.
- Input accepted only when i_DV=1, i_pixel_x<WIDTH, i_pixel_y<HEIGHT; otherwise ignored (no write, no output).
- frame_ok flag: cleared by reset; set by accepted pixel at (0,0). No output while frame_ok=0.
- Output generated when accepted input has x>=2, y>=2, frame_ok=1 (including this pixel if it is (0,0) — never qualifies). Window centre = (x-1, y-1). Output covers interior only: x in 1..WIDTH-2, y in 1..HEIGHT-2; (WIDTH-2)*(HEIGHT-2) outputs per frame.
- Centre phase from (cx[0], cy[0]) XOR PATTERN bits -> {B, G_on_B_row, G_on_R_row, R}.
- Interpolation (c=centre, N/S/E/W orthogonal, D diagonals):
  - B site: B=c; G=(N+S+E+W)>>2; R=(4 diag)>>2.
  - R site: R=c; G=(N+S+E+W)>>2; B=(4 diag)>>2.
  - G on B row: G=c; B=(E+W)>>1; R=(N+S)>>1.
  - G on R row: G=c; R=(E+W)>>1; B=(N+S)>>1.
- Sums: 4-term 10 bits, 2-term 9 bits, truncating shift, no rounding; result always 8 bits, no saturation needed.
- Pack RGB565 by truncation of low bits.

## Timing
- Pipeline, no stall, no backpressure: S1 line-buffer read, S2 window shift + coordinate/phase compute, S3 interpolate + output register.
- Latency: o_DV asserted exactly 3 PCLK after the PCLK edge sampling the qualifying i_DV, regardless of input gaps (back-to-back or every 2nd PCLK).
- Output fields (o_RGB, coords, o_addr) update only with o_DV; hold last value otherwise.
- Reset values: o_RGB=0, o_DV=0, o_pixel_x=0, o_pixel_y=0, o_addr=0; pipeline valids and frame_ok=0. Line-buffer RAM not reset.
- Reset mid-frame: in-flight pixels dropped; no o_DV until after next accepted (0,0) plus two rows.
- New (0,0) mid-frame (short frame): treated as new frame start; stale line data never reaches output because y>=2 gate.

## Structure
- Package bayer_pkg: phase enum {PH_B, PH_GB, PH_GR, PH_R}, phase-from-parity function, RGB565 pack function, latency constant DEMOSAIC_LAT=3.
- Sub-module line_buffer: single-clock simple dual-port RAM, WIDTH x 8, 1-cycle synchronous read, read-before-write; instantiated twice.

## Test plan
- Use WIDTH=8, HEIGHT=6 unless stated.
- Flat field 0x80 everywhere -> every output 0x8410; exactly 24 o_DV pulses per frame.
- Red-only scene (R sites 0xFF, others 0), PATTERN=0 -> every output 0xF800.
- First output: input (2,2) -> o_DV 3 PCLK later with o_pixel_x=1, o_pixel_y=1, o_addr=9; no o_DV for any x<2 or y<2 input.
- Same random frame driven back-to-back and with i_DV every 2nd PCLK -> identical o_RGB/o_addr sequences, latency 3 in both.
- Assert RST_N low during row 3 -> all outputs 0 immediately; after release, continue row 3–5 -> no o_DV; next frame from (0,0) -> normal 24 outputs.
- Horizontal ramp pixel=16*x, G on B row at centre (3,2) -> B=(32+64)>>1=48, R=48, G=48 -> o_RGB=0x3186.
